// File: rtl/branch_comparator_seq_if.sv
// branch_comparator_seq_if: request/result bundle between the control FSM and the sliced branch comparator.
interface branch_comparator_seq_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [2:0]       op_i;
  logic             ready_o;
  logic             valid_o;
  logic             r_o;
  modport master (output start_i, a_i, b_i, op_i, input ready_o, valid_o, r_o);
  modport slave  (input start_i, a_i, b_i, op_i, output ready_o, valid_o, r_o);
endinterface

// File: rtl/branch_comparator_seq.sv
// branch_comparator_seq: multi-cycle RV32I branch condition evaluator, SLICE bits per cycle, MSB first.
// Optional BRCMP_EARLY_EXIT_EN finishes as soon as the first differing slice decides the result.
module branch_comparator_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic clk_i,
  input logic rst_i,
  branch_comparator_seq_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  if (SLICE < 1 || SLICE > WIDTH || WIDTH % SLICE != 0) begin : g_bad_params
    $error("branch_comparator_seq: WIDTH must be a nonzero multiple of SLICE");
  end
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, a_x, b_x, sign_mask;
  logic [2:0]       op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SLICE-1:0] sa, sb;
  logic             eq_q, eq_d, lt_q, lt_d;
  logic             ready_q, ready_d, valid_q, valid_d, r_q, r_d;
  logic             differ, last;
  // Flipping the sign bit turns a signed compare into an unsigned one.
  assign sign_mask = {WIDTH{op_q[2] & ~op_q[1]}} & (WIDTH'(1) << (WIDTH - 1));
  assign a_x    = a_q ^ sign_mask;
  assign b_x    = b_q ^ sign_mask;
  assign sa     = a_x[idx_q*SLICE +: SLICE];
  assign sb     = b_x[idx_q*SLICE +: SLICE];
  assign differ = eq_q && (sa != sb);
`ifdef BRCMP_EARLY_EXIT_EN
  assign last   = (idx_q == '0) || differ;
`else
  assign last   = (idx_q == '0);
`endif
  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.r_o     = r_q;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    valid_d = 1'b0;
    r_d     = r_q;
    if (ready_q && bus.start_i) begin
      a_d     = bus.a_i;
      b_d     = bus.b_i;
      op_d    = bus.op_i;
      eq_d    = 1'b1;
      lt_d    = 1'b0;
      idx_d   = IW'(N - 1);
      state_d = CMP;
    end else if (state_q == CMP) begin
      eq_d    = differ ? 1'b0 : eq_q;
      lt_d    = differ ? (sa < sb) : lt_q;
      idx_d   = last ? idx_q : idx_q - 1'b1;
      state_d = last ? DONE : CMP;
      valid_d = last;
      r_d     = last ? (op_q[2] ? (lt_d ^ op_q[0]) : (~op_q[1] & (eq_d ^ op_q[0]))) : r_q;
    end else begin
      state_d = IDLE;
    end
    ready_d = (state_d != CMP);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= IW'(N - 1);
      eq_q    <= 1'b1;
      lt_q    <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      r_q     <= r_d;
    end
  end
endmodule

// File: tb/tb_branch_comparator_seq.sv
// tb_branch_comparator_seq: directed vector table plus reset and back-to-back sequences.
module tb_branch_comparator_seq;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  branch_comparator_seq_if #(.WIDTH(32)) bus ();
  branch_comparator_seq #(.WIDTH(32), .SLICE(8)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        r;
    int          lat_ee;
  } vec_t;
  vec_t vecs[14];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    @(negedge clk_i);
    bus.a_i = a;
    bus.b_i = b;
    bus.op_i = op;
    bus.start_i = 1'b1;
    @(posedge clk_i);
    #1 bus.start_i = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 1;
    while (bus.valid_o !== 1'b1 && lat < 20) begin
      @(posedge clk_i);
      #1 lat++;
    end
  endtask
  initial begin
    int lat, exp_lat, nv;
    bus.start_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.op_i = '0;
    vecs[0]  = '{32'h12345678, 32'h12345678, 3'b000, 1'b1, 5};
    vecs[1]  = '{32'h12345678, 32'h12345678, 3'b001, 1'b0, 5};
    vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 3'b100, 1'b1, 2};
    vecs[3]  = '{32'hFFFFFFFF, 32'h00000001, 3'b101, 1'b0, 2};
    vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 3'b110, 1'b0, 2};
    vecs[5]  = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 1'b1, 2};
    vecs[6]  = '{32'h80000000, 32'h7FFFFFFF, 3'b100, 1'b1, 2};
    vecs[7]  = '{32'h80000000, 32'h7FFFFFFF, 3'b110, 1'b0, 2};
    vecs[8]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 3'b100, 1'b1, 5};
    vecs[9]  = '{32'h01000000, 32'h02000000, 3'b100, 1'b1, 2};
    vecs[10] = '{32'h01000000, 32'h02000000, 3'b010, 1'b0, 2};
    vecs[11] = '{32'h00000005, 32'h00000005, 3'b011, 1'b0, 5};
    vecs[12] = '{32'h00000100, 32'h00000200, 3'b111, 1'b0, 4};
    vecs[13] = '{32'h12345678, 32'h12345679, 3'b001, 1'b1, 5};
    #12;
    check("reset_ready", bus.ready_o, 1);
    check("reset_valid", bus.valid_o, 0);
    check("reset_r", bus.r_o, 0);
    @(negedge clk_i) rst_i = 1'b0;
    foreach (vecs[i]) begin
`ifdef BRCMP_EARLY_EXIT_EN
      exp_lat = vecs[i].lat_ee;
`else
      exp_lat = 5;
`endif
      launch(vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("v%0d_busy", i), bus.ready_o, 0);
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), lat, exp_lat);
      check($sformatf("v%0d_r", i), bus.r_o, vecs[i].r);
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_valid_drop", i), bus.valid_o, 0);
      check($sformatf("v%0d_r_hold", i), bus.r_o, vecs[i].r);
    end
    launch(32'h12345678, 32'h12345678, 3'b000);
    wait_valid(lat);
    check("pre_reset_r", bus.r_o, 1);
    launch(32'h00000001, 32'h00000002, 3'b110);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("midreset_ready", bus.ready_o, 1);
    check("midreset_valid", bus.valid_o, 0);
    check("midreset_r", bus.r_o, 0);
    @(negedge clk_i) rst_i = 1'b0;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i);
      #1 if (bus.valid_o === 1'b1) nv++;
    end
    check("midreset_no_valid", nv, 0);
    launch(32'h00000001, 32'h00000002, 3'b110);
    wait_valid(lat);
    check("b2b_first_r", bus.r_o, 1);
    bus.a_i = 32'h00000005;
    bus.b_i = 32'h00000003;
    bus.op_i = 3'b110;
    bus.start_i = 1'b1;
    @(posedge clk_i);
    #1 bus.start_i = 1'b0;
    check("b2b_valid_drop", bus.valid_o, 0);
    check("b2b_accepted", bus.ready_o, 0);
    check("b2b_r_held", bus.r_o, 1);
    @(negedge clk_i);
    bus.a_i = 32'h00000000;
    bus.b_i = 32'hFFFFFFFF;
    bus.op_i = 3'b000;
    bus.start_i = 1'b1;
    @(negedge clk_i) bus.start_i = 1'b0;
    lat = 2;
    nv = 0;
    while (bus.valid_o !== 1'b1 && lat < 20) begin
      if (bus.r_o !== 1'b1) nv++;
      @(posedge clk_i);
      #1 lat++;
    end
    check("b2b_r_held_during_cmp", nv, 0);
    check("b2b_second_latency", lat, 5);
    check("b2b_second_r", bus.r_o, 0);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i);
      #1 if (bus.valid_o === 1'b1) nv++;
    end
    check("cmp_start_ignored", nv, 0);
    check("final_r_hold", bus.r_o, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
